yuv2rgb_frame_ctrl: RTL and testbench
=====================================

Name: yuv2rgb_frame_ctrl

Overview:
Frame sequencer for the YUV->RGB conversion path. On a start pulse it walks a frame-sized Y/U/V pixel memory and issues one read per cycle. It drives the converter pipeline enable and tracks in-flight pixels through a valid delay line matching the converter latency. It then asserts the RGB write strobe as each result emerges, and reports frame completion. It sits between the pixel memory/RGB sink and the yuv2rgb arithmetic pipeline.

Parameters:
IMG_W, 1920, pixels per line
IMG_H, 1080, lines per frame
ADDR_W, 32, memory address width
PIPE_LAT, 3, converter latency in enabled cycles (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle frame start request
base_addr  in  ADDR_W  frame base address, latched on accepted start
hold  in  1  stall; freezes issue, delay line and write strobe
mem_addr  out  ADDR_W  read address to pixel memory
mem_read  out  1  read strobe; Y/U/V data valid the same cycle
cvt_en  out  1  converter pipeline clock enable
mem_write  out  1  RGB write strobe, aligned with converter output
wr_cnt  out  32  number of RGB writes completed this frame
pix_x  out  16  column of the pixel currently issued
pix_y  out  16  line of the pixel currently issued
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. mem_addr=0. Delay line cleared. Reset mid-frame abandons the frame with no further writes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches base_addr and goes to RUN. The first issue occurs in the next cycle.
- RUN, hold=0 (issue cycle):
  - mem_read=1, cvt_en=1, mem_addr=base+idx with idx 0..IMG_W*IMG_H-1.
  - idx advances by 1 each issue cycle.
  - pix_x wraps IMG_W-1 -> 0 and increments pix_y.
  - The issue with idx=IMG_W*IMG_H-1 moves the state to DRAIN.
- RUN, hold=1: mem_read=0, cvt_en=0. Address, counters and delay line are frozen. mem_write=0.
- Delay line: PIPE_LAT-bit shift register, shifted only when cvt_en=1.
  - Input bit = mem_read.
  - mem_write = last bit AND cvt_en.
  - Each write therefore occurs exactly PIPE_LAT enabled cycles after its issue.
- wr_cnt increments on each mem_write and is cleared on an accepted start.
- DRAIN:
  - mem_read=0. cvt_en=!hold.
  - Stays until the delay line is empty after the final write, then goes to DONE.
  - hold extends DRAIN cycle-for-cycle.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- start outside IDLE is ignored; there is no queueing.
- start in the DONE cycle is ignored.
- Invariants:
  - Reads per frame = writes per frame = IMG_W*IMG_H.
  - mem_addr wraps modulo 2^ADDR_W if base+idx overflows.
- Width rules: the idx counter is wide enough for IMG_W*IMG_H. pix_x and pix_y are zero-extended to 16 bits.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the PIPE_LAT default constant, shared with the yuv2rgb converter so the two cannot diverge.
- One sub-module: yuv2rgb_vld_pipe, the enabled valid shift register of depth PIPE_LAT with an empty flag.
- FSM, address and coordinate counters stay in the top module.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=2, PIPE_LAT=3, base=0x100, start at cycle 0.
  - mem_read in cycles 1-8 with mem_addr 0x100..0x107.
  - mem_write in cycles 4-11.
  - frame_done=1 in cycle 12; busy low from cycle 12.
  - wr_cnt=8.
- Hold in RUN: same setup with hold=1 in cycles 3-4.
  - mem_addr stays 0x102 through the stall and no writes occur in cycles 3-4.
  - Last read in cycle 10, last write in cycle 13, frame_done in cycle 14.
- Hold in DRAIN: hold=1 for 2 cycles after the last issue.
  - Last write is delayed by 2 cycles and frame_done by 2 cycles.
  - Total writes = 8.
- Start while busy: start pulse at cycle 5.
  - Ignored; identical trace to the basic frame.
  - A second start after frame_done runs a new frame and clears wr_cnt.
- Async reset mid-frame: rst_n low at cycle 6 (between edges).
  - All outputs 0 immediately and state IDLE.
  - No mem_write after release until a new start.
- Coordinate wrap: IMG_W=4.
  - pix_x sequence 0,1,2,3,0,1,2,3.
  - pix_y 0 for the first four issues, then 1.

Source files
------------

// File: rtl/yuv2rgb_frame_ctrl_pkg.sv
// yuv2rgb_frame_ctrl_pkg: frame sequencer state encoding and converter latency shared with the yuv2rgb pipeline
package yuv2rgb_frame_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int PIPE_LAT_DEF = 3;
endpackage

// File: rtl/yuv2rgb_vld_pipe.sv
// yuv2rgb_vld_pipe: enabled valid shift register tracking in-flight pixels through the converter
module yuv2rgb_vld_pipe
  import yuv2rgb_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic last,
  output logic empty
);
  logic [DEPTH-1:0] sr, nxt;
  assign nxt   = (sr << 1) | DEPTH'(din);
  assign last  = sr[DEPTH-1];
  // empty looks one shift ahead so the sequencer can leave DRAIN on the final write
  assign empty = en ? nxt == '0 : sr == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (en) sr <= nxt;
endmodule

// File: rtl/yuv2rgb_frame_ctrl.sv
// yuv2rgb_frame_ctrl: walks a Y/U/V frame one read per cycle, enables the converter
// and strobes RGB writes as results emerge PIPE_LAT enabled cycles later
module yuv2rgb_frame_ctrl
  import yuv2rgb_frame_ctrl_pkg::*;
#(
  parameter int IMG_W    = 1920,
  parameter int IMG_H    = 1080,
  parameter int ADDR_W   = 32,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              cvt_en,
  output logic              mem_write,
  output logic [31:0]       wr_cnt,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              busy,
  output logic              frame_done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int IW   = $clog2(NPIX + 1);
  state_t        state;
  logic [IW-1:0] idx;
  logic          last_bit, empty, eol;
  assign busy       = state == RUN || state == DRAIN;
  assign mem_read   = state == RUN && !hold;
  assign cvt_en     = busy && !hold;
  assign mem_write  = last_bit && cvt_en;
  assign frame_done = state == DONE;
  assign eol        = pix_x == 16'(IMG_W - 1);
  yuv2rgb_vld_pipe #(.DEPTH(PIPE_LAT)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cvt_en),
    .din   (mem_read),
    .last  (last_bit),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      mem_addr <= '0;
      wr_cnt   <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else begin
      if (mem_write) wr_cnt <= wr_cnt + 32'd1;
      unique case (state)
        IDLE: if (start) begin
          state    <= RUN;
          mem_addr <= base_addr;
          idx      <= '0;
          wr_cnt   <= '0;
          pix_x    <= '0;
          pix_y    <= '0;
        end
        RUN: if (!hold) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          idx      <= idx + IW'(1);
          pix_x    <= eol ? 16'd0 : pix_x + 16'd1;
          pix_y    <= eol ? pix_y + 16'd1 : pix_y;
          if (idx == IW'(NPIX - 1)) state <= DRAIN;
        end
        DRAIN: if (cvt_en && empty) state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_yuv2rgb_frame_ctrl.sv
// tb_yuv2rgb_frame_ctrl: table of frame scenarios checked against a scoreboard of expected reads/writes
module tb_yuv2rgb_frame_ctrl;
  localparam int W = 4, H = 2, LAT = 3, N = W * H;
  logic        clk = 0, rst_n = 0, start = 0, hold = 0;
  logic [31:0] base_addr = 0, mem_addr, wr_cnt;
  logic        mem_read, cvt_en, mem_write, busy, frame_done;
  logic [15:0] pix_x, pix_y;
  int          n_chk = 0, n_pass = 0;

  yuv2rgb_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(32), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .hold(hold),
    .mem_addr(mem_addr), .mem_read(mem_read), .cvt_en(cvt_en), .mem_write(mem_write),
    .wr_cnt(wr_cnt), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hmask;
    logic [31:0] base;
    int          start2;
    int          last_rd;
    int          last_wr;
    int          done;
  } scn_t;
  typedef struct {
    int          c;
    logic [31:0] a;
    int          x;
    int          y;
  } rd_t;

  scn_t tbl[5];
  rd_t  rd_q[$];
  int   wr_q[$];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask

  task automatic chk_zero(input string n);
    chk({n, " mem_addr"}, 64'(mem_addr), 0);
    chk({n, " mem_read"}, 64'(mem_read), 0);
    chk({n, " cvt_en"}, 64'(cvt_en), 0);
    chk({n, " mem_write"}, 64'(mem_write), 0);
    chk({n, " wr_cnt"}, 64'(wr_cnt), 0);
    chk({n, " pix_x"}, 64'(pix_x), 0);
    chk({n, " pix_y"}, 64'(pix_y), 0);
    chk({n, " busy"}, 64'(busy), 0);
    chk({n, " frame_done"}, 64'(frame_done), 0);
  endtask

  function automatic logic hbit(input logic [31:0] m, input int c);
    return c < 32 ? m[c] : 1'b0;
  endfunction

  task automatic run_scn(input scn_t s);
    int c = 1, en_i = 0, issued = 0, writes = 0, mdone;
    int pend[$];
    int rd_seen = 0, last_rd = -1, last_wr = -1, done_c = -1;
    rd_q.delete();
    wr_q.delete();
    while (writes < N && c < 64) begin
      if (!hbit(s.hmask, c)) begin
        if (pend.size() > 0 && pend[0] == en_i) begin
          void'(pend.pop_front());
          wr_q.push_back(c);
          writes++;
        end
        if (issued < N) begin
          rd_q.push_back('{c, s.base + 32'(issued), issued % W, issued / W});
          pend.push_back(en_i + LAT);
          issued++;
        end
        en_i++;
      end
      c++;
    end
    mdone = c;
    chk({s.name, " model done"}, 64'(mdone), 64'(s.done));
    @(posedge clk);
    #1 start = 1; base_addr = s.base; hold = hbit(s.hmask, 0);
    for (int k = 1; k <= s.done + 3; k++) begin
      @(posedge clk);
      #1 start = (k == s.start2); hold = hbit(s.hmask, k);
      base_addr = 32'hDEAD_0000;
      @(negedge clk);
      if (k == 1) chk({s.name, " wr_cnt cleared"}, 64'(wr_cnt), 0);
      if (hold && busy && rd_seen < N)
        chk({s.name, " addr frozen"}, 64'(mem_addr), 64'(s.base + 32'(rd_seen)));
      if (mem_read) begin
        if (rd_q.size() == 0) chk({s.name, " unexpected read"}, 64'(k), 0);
        else begin
          rd_t r = rd_q.pop_front();
          chk({s.name, " read cycle"}, 64'(k), 64'(r.c));
          chk({s.name, " read addr"}, 64'(mem_addr), 64'(r.a));
          chk({s.name, " pix_x"}, 64'(pix_x), 64'(r.x));
          chk({s.name, " pix_y"}, 64'(pix_y), 64'(r.y));
        end
        rd_seen++;
        last_rd = k;
      end
      if (mem_write) begin
        if (wr_q.size() == 0) chk({s.name, " unexpected write"}, 64'(k), 0);
        else chk({s.name, " write cycle"}, 64'(k), 64'(wr_q.pop_front()));
        last_wr = k;
      end
      if (frame_done) begin
        if (done_c < 0) done_c = k;
        chk({s.name, " wr_cnt at done"}, 64'(wr_cnt), 64'(N));
        chk({s.name, " busy at done"}, 64'(busy), 0);
      end
    end
    start = 0;
    hold = 0;
    chk({s.name, " last read"}, 64'(last_rd), 64'(s.last_rd));
    chk({s.name, " last write"}, 64'(last_wr), 64'(s.last_wr));
    chk({s.name, " done cycle"}, 64'(done_c), 64'(s.done));
    chk({s.name, " reads left"}, 64'(rd_q.size()), 0);
    chk({s.name, " writes left"}, 64'(wr_q.size()), 0);
  endtask

  initial begin
    tbl[0] = '{"basic", 32'h0, 32'h100, -1, 8, 11, 12};
    tbl[1] = '{"hold_run", 32'h18, 32'h100, -1, 10, 13, 14};
    tbl[2] = '{"hold_drain", 32'h600, 32'h100, -1, 8, 13, 14};
    tbl[3] = '{"start_busy", 32'h0, 32'h100, 5, 8, 11, 12};
    tbl[4] = '{"addr_wrap", 32'h0, 32'hFFFF_FFFC, -1, 8, 11, 12};
    #12;
    chk_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 5; i++) run_scn(tbl[i]);
    @(posedge clk);
    #1 start = 1; base_addr = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 start = 0;
    end
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_zero("async reset");
    @(posedge clk);
    #2 rst_n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post reset write", 64'(mem_write), 0);
      chk("post reset read", 64'(mem_read), 0);
    end
    run_scn(tbl[0]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
